// File: rtl/oerv_pkg.sv
// ============================================================================
// oerv_pkg : shared state encoding and beat-count helpers for the OERV sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package oerv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RF    = 3'd2,
        ST_INIT  = 3'd3,
        ST_MEM   = 3'd4,
        ST_RUN   = 3'd5
    } state_e;

    localparam int unsigned WORD_BITS = 32;

    function automatic int unsigned beats_per_stage(input int unsigned w);
        return WORD_BITS / w;
    endfunction

    function automatic int unsigned beat_cnt_width(input int unsigned w);
        return $clog2(WORD_BITS / w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/oerv_beat_cnt.sv
// ============================================================================
// oerv_beat_cnt : serial beat counter, first/last-beat flags for one stage
// Rev 1.0
// ============================================================================
`default_nettype none

module oerv_beat_cnt
    import oerv_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_cnt0,
    output logic o_cnt_done
);

    localparam int unsigned          N    = beats_per_stage(W);
    localparam int unsigned          CW   = beat_cnt_width(W);
    localparam logic [CW-1:0]        LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Held at zero whenever no stage is active, so every stage entry starts at beat 0.
    always_comb begin
        cnt_d = '0;
        if (i_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt0     = i_en && (cnt_q == '0);
    assign o_cnt_done = i_en && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/oerv_seq.sv
// ============================================================================
// oerv_seq : fetch / register-read / init / mem / run sequencer, byte-serial core
// Optional feature macro: OERV_MISALIGN_EN (misalign trap register)
// Rev 1.0
// ============================================================================
`default_nettype none

module oerv_seq
    import oerv_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_ibus_cyc,
    input  logic i_ibus_ack,
    output logic o_decode_en,
    input  logic i_two_stage,
    input  logic i_mem_op,
    input  logic i_misalign,
    output logic o_rf_rreq,
    input  logic i_rf_ready,
    output logic o_dbus_cyc,
    input  logic i_dbus_ack,
    output logic o_cnt_en,
    output logic o_cnt0,
    output logic o_cnt_done,
    output logic o_init,
    output logic o_pc_en,
    output logic o_trap
);

    state_e state_q;
    state_e state_d;
    logic   rreq_done_q;
    logic   w_cnt_en;
    logic   w_trap_take;

    assign w_cnt_en = (state_q == ST_INIT) || (state_q == ST_RUN);
    assign o_cnt_en = w_cnt_en;

    oerv_beat_cnt #(.W(W)) u_beat_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (w_cnt_en),
        .o_cnt0     (o_cnt0),
        .o_cnt_done (o_cnt_done)
    );

`ifdef OERV_MISALIGN_EN
    logic trap_q;

    assign w_trap_take = i_misalign;

    // Captured on the last init beat; lives exactly for the following RUN stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trap_q <= 1'b0;
        end else if ((state_q == ST_INIT) && o_cnt_done) begin
            trap_q <= i_misalign;
        end else if ((state_q == ST_RUN) && o_cnt_done) begin
            trap_q <= 1'b0;
        end
    end

    assign o_trap = trap_q && (state_q == ST_RUN);
`else
    logic w_unused_misalign;

    assign w_unused_misalign = i_misalign;
    assign w_trap_take       = 1'b0;
    assign o_trap            = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            rreq_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rreq_done_q <= (state_q == ST_RF);
        end
    end

    always_comb begin
        state_d     = state_q;
        o_ibus_cyc  = 1'b0;
        o_decode_en = 1'b0;
        o_rf_rreq   = 1'b0;
        o_dbus_cyc  = 1'b0;
        o_init      = 1'b0;
        o_pc_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                o_ibus_cyc = 1'b1;
                if (i_ibus_ack) begin
                    o_decode_en = 1'b1;
                    state_d     = ST_RF;
                end
            end
            ST_RF: begin
                o_rf_rreq = !rreq_done_q;
                if (i_rf_ready) begin
                    state_d = i_two_stage ? ST_INIT : ST_RUN;
                end
            end
            ST_INIT: begin
                o_init = 1'b1;
                if (o_cnt_done) begin
                    state_d = (i_mem_op && !w_trap_take) ? ST_MEM : ST_RUN;
                end
            end
            ST_MEM: begin
                o_dbus_cyc = 1'b1;
                if (i_dbus_ack) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (o_cnt_done) begin
                    o_pc_en = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_oerv_seq.sv
// ============================================================================
// tb_oerv_seq : randomized instruction-level bench for oerv_seq
// Honours OERV_MISALIGN_EN when defined for the build.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_oerv_seq;

    localparam int unsigned W = 8;
    localparam int          N = 32 / W;

`ifdef OERV_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ibus_ack = 1'b0, rf_ready = 1'b0, dbus_ack = 1'b0;
    logic two_stage = 1'b0, mem_op = 1'b0, misalign = 1'b0;
    logic ibus_cyc, decode_en, rf_rreq, dbus_cyc, cnt_en, cnt0, cnt_done, init, pc_en, trap;

    always #5 clk = ~clk;

    oerv_seq #(.W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_ibus_cyc  (ibus_cyc),
        .i_ibus_ack  (ibus_ack),
        .o_decode_en (decode_en),
        .i_two_stage (two_stage),
        .i_mem_op    (mem_op),
        .i_misalign  (misalign),
        .o_rf_rreq   (rf_rreq),
        .i_rf_ready  (rf_ready),
        .o_dbus_cyc  (dbus_cyc),
        .i_dbus_ack  (dbus_ack),
        .o_cnt_en    (cnt_en),
        .o_cnt0      (cnt0),
        .o_cnt_done  (cnt_done),
        .o_init      (init),
        .o_pc_en     (pc_en),
        .o_trap      (trap)
    );

    // {ibus_cyc, decode_en, rf_rreq, dbus_cyc, cnt_en, cnt0, cnt_done, init, pc_en, trap}
    wire [9:0] w_obs = {ibus_cyc, decode_en, rf_rreq, dbus_cyc, cnt_en,
                        cnt0, cnt_done, init, pc_en, trap};

    typedef struct {
        logic       ibus_ack;
        logic       rf_ready;
        logic       dbus_ack;
        logic       two_stage;
        logic       mem_op;
        logic       misalign;
        logic [9:0] exp;
    } cyc_t;

    cyc_t sched[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic cur_two  = 1'b0;
    logic cur_mem  = 1'b0;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs(input bit ibus, input bit dec, input bit rreq,
                                        input bit dbus, input bit cen, input bit c0,
                                        input bit cd, input bit ini, input bit pc,
                                        input bit trp);
        return {ibus, dec, rreq, dbus, cen, c0, cd, ini, pc, trp};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic ia, input logic rr, input logic da,
                        input logic mis, input logic [9:0] e);
        cyc_t c;
        c.ibus_ack  = ia;
        c.rf_ready  = rr;
        c.dbus_ack  = da;
        c.two_stage = cur_two;
        c.mem_op    = cur_mem;
        c.misalign  = mis;
        c.exp       = e;
        sched.push_back(c);
    endtask

    // One instruction as a cycle-by-cycle expectation, starting in the fetch state.
    // Acks that the sequencer must ignore in a given phase are driven randomly.
    task automatic add_instr(input int f, input int r, input bit two, input bit mem,
                             input int d, input bit mis);
        bit trp;
        trp = MIS_EN && two && mis;
        for (int k = 0; k < f; k++)
            push(1'b0, rnd(), rnd(), rnd(), outs(1,0,0,0,0,0,0,0,0,0));
        cur_two = two;
        cur_mem = mem;
        push(1'b1, rnd(), rnd(), rnd(), outs(1,1,0,0,0,0,0,0,0,0));
        for (int k = 0; k <= r; k++)
            push(rnd(), k == r, rnd(), rnd(), outs(0,0,k==0,0,0,0,0,0,0,0));
        if (two) begin
            for (int k = 0; k < N; k++)
                push(rnd(), rnd(), rnd(), (k == N-1) ? mis : rnd(),
                     outs(0,0,0,0,1,k==0,k==N-1,1,0,0));
            if (mem && !trp) begin
                for (int k = 0; k <= d; k++)
                    push(rnd(), rnd(), k == d, rnd(), outs(0,0,0,1,0,0,0,0,0,0));
            end
        end
        for (int k = 0; k < N; k++)
            push(rnd(), rnd(), rnd(), rnd(), outs(0,0,0,0,1,k==0,k==N-1,0,k==N-1,trp));
    endtask

    // Plays the schedule; a nonzero stop_dbus returns after that many data-bus cycles.
    task automatic run_sched(input int stop_dbus);
        cyc_t c;
        int   idx;
        int   nd;
        idx = 0;
        nd  = 0;
        while (sched.size() > 0) begin
            c = sched.pop_front();
            @(posedge clk);
            #1;
            ibus_ack  = c.ibus_ack;
            rf_ready  = c.rf_ready;
            dbus_ack  = c.dbus_ack;
            two_stage = c.two_stage;
            mem_op    = c.mem_op;
            misalign  = c.misalign;
            #4;
            check($sformatf("cyc%0d", idx), w_obs, c.exp);
            idx++;
            if (c.exp[6]) nd++;
            if (stop_dbus != 0 && nd >= stop_dbus) return;
        end
    endtask

    task automatic zero_inputs();
        ibus_ack = 1'b0;
        rf_ready = 1'b0;
        dbus_ack = 1'b0;
        misalign = 1'b0;
    endtask

    initial begin
        zero_inputs();
        repeat (3) begin
            @(posedge clk);
            #5;
            check("reset", w_obs, outs(0,0,0,0,0,0,0,0,0,0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #4;
        check("idle", w_obs, outs(0,0,0,0,0,0,0,0,0,0));

        add_instr(5, 0, 1'b0, 1'b0, 0, 1'b0);
        add_instr(0, 0, 1'b0, 1'b0, 0, 1'b0);
        add_instr(0, 0, 1'b1, 1'b1, 3, 1'b0);
        add_instr(0, 0, 1'b1, 1'b0, 0, 1'b0);
        add_instr(0, 1, 1'b1, 1'b1, 2, 1'b1);
        add_instr(1, 2, 1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 60; i++)
            add_instr($urandom_range(0, 3), $urandom_range(0, 3), rnd(), rnd(),
                      $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
        run_sched(0);

        // Asynchronous reset in the middle of a held data-bus request.
        add_instr(0, 0, 1'b1, 1'b1, 10, 1'b0);
        run_sched(3);
        #1;
        rst_n = 1'b0;
        zero_inputs();
        #1;
        check("rst_mem", w_obs, outs(0,0,0,0,0,0,0,0,0,0));
        sched.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #4;
        check("rst_idle", w_obs, outs(0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #5;
        check("rst_fetch", w_obs, outs(1,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #5;
        check("rst_fetch_hold", w_obs, outs(1,0,0,0,0,0,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
